// File: rtl/lfsr_pkg.sv
// Shared LFSR definitions: form selection and the single-step function.
// The design and its bench model both use these.
package lfsr_pkg;

    localparam int LFSR_MAX_W = 64;
    localparam int LFSR_IDX_W = $clog2(LFSR_MAX_W);

    typedef logic [LFSR_MAX_W-1:0] lfsr_word_t;

    typedef enum logic {
        LFSR_FIB    = 1'b0,
        LFSR_GALOIS = 1'b1
    } lfsr_mode_e;

    // Operands are zero-extended into a wide word, so one body covers every width up to LFSR_MAX_W.
    function automatic lfsr_word_t lfsr_next(input lfsr_word_t state,
                                             input lfsr_word_t taps,
                                             input lfsr_mode_e galois,
                                             input int         width);
        lfsr_word_t nxt;
        nxt = state >> 1;
        if (galois == LFSR_GALOIS) begin
            if (state[0]) begin
                nxt = nxt ^ taps;
            end
        end else begin
            nxt[LFSR_IDX_W'(width - 1)] = ^(state & taps);
        end
        return nxt;
    endfunction

endpackage

// File: rtl/lfsr_gen_if.sv
// Control and observation bundle of one LFSR generator instance.
interface lfsr_gen_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0] seed;
    logic             load;
    logic             en;
    logic [WIDTH-1:0] state;
    logic             out_bit;
    logic             lockup;
    logic [WIDTH-1:0] period;
    logic             period_valid;

    modport master (
        output seed, load, en,
        input  state, out_bit, lockup, period, period_valid
    );

    modport slave (
        input  seed, load, en,
        output state, out_bit, lockup, period, period_valid
    );
endinterface

// File: rtl/lfsr_period_mon.sv
// On-line period counter: counts steps since the reference seed was last seen
// and reports the cycle length each time the sequence returns to it.
module lfsr_period_mon
    import lfsr_pkg::*;
#(
    parameter int               WIDTH      = 8,
    parameter logic [WIDTH-1:0] RESET_SEED = WIDTH'(1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             recover,
    input  logic             step,
    input  logic [WIDTH-1:0] seed,
    input  logic [WIDTH-1:0] next_state,
    output logic [WIDTH-1:0] period,
    output logic             period_valid
);

    logic [WIDTH-1:0] ref_seed;
    logic [WIDTH-1:0] step_cnt;

    // A saturated counter means the reference was lost; stay silent until a new reference is set.
    always_ff @(posedge clk) begin
        if (rst) begin
            ref_seed     <= RESET_SEED;
            step_cnt     <= '0;
            period       <= '0;
            period_valid <= 1'b0;
        end else begin
            period_valid <= 1'b0;
            if (load) begin
                ref_seed <= seed;
                step_cnt <= '0;
            end else if (recover) begin
                ref_seed <= RESET_SEED;
                step_cnt <= '0;
            end else if (step && (step_cnt != '1)) begin
                if (next_state == ref_seed) begin
                    period       <= step_cnt + 1'b1;
                    period_valid <= 1'b1;
                    step_cnt     <= '0;
                end else begin
                    step_cnt <= step_cnt + 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/lfsr_gen.sv
// Parametrised Fibonacci/Galois LFSR with seed load, lockup detection,
// optional auto-recovery from the all-zero state and a period monitor.
module lfsr_gen
    import lfsr_pkg::*;
#(
    parameter int               WIDTH        = 8,
    parameter logic [WIDTH-1:0] TAPS         = 8'hB8,
    parameter int               GALOIS       = 0,
    parameter logic [WIDTH-1:0] RESET_SEED   = WIDTH'(1),
    parameter int               AUTO_RECOVER = 1
) (
    input  logic       clk,
    input  logic       rst,
    lfsr_gen_if.slave  bus
);

    localparam lfsr_mode_e MODE = (GALOIS != 0) ? LFSR_GALOIS : LFSR_FIB;

    logic [WIDTH-1:0] state_q;
    logic [WIDTH-1:0] state_d;
    logic [WIDTH-1:0] step_next;
    logic             lockup_q;
    logic             recover;
    logic             step;
    logic [WIDTH-1:0] period;
    logic             period_valid;

    always_comb begin
        step_next = WIDTH'(lfsr_next(lfsr_word_t'(state_q), lfsr_word_t'(TAPS), MODE, WIDTH));
    end

    // Load beats step; a step taken while locked up becomes a reseed when recovery is enabled.
    always_comb begin
        state_d = state_q;
        recover = 1'b0;
        step    = 1'b0;
        if (bus.load) begin
            state_d = bus.seed;
        end else if (bus.en) begin
            if ((AUTO_RECOVER != 0) && lockup_q) begin
                recover = 1'b1;
                state_d = RESET_SEED;
            end else begin
                step    = 1'b1;
                state_d = step_next;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= RESET_SEED;
            lockup_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            lockup_q <= (state_d == '0);
        end
    end

    lfsr_period_mon #(
        .WIDTH      (WIDTH),
        .RESET_SEED (RESET_SEED)
    ) u_period_mon (
        .clk          (clk),
        .rst          (rst),
        .load         (bus.load),
        .recover      (recover),
        .step         (step),
        .seed         (bus.seed),
        .next_state   (step_next),
        .period       (period),
        .period_valid (period_valid)
    );

    assign bus.state        = state_q;
    assign bus.out_bit      = state_q[0];
    assign bus.lockup       = lockup_q;
    assign bus.period       = period;
    assign bus.period_valid = period_valid;

endmodule

// File: doc/lfsr_gen.md
# lfsr_gen

Parametrised linear-feedback shift register, the general successor to the fixed 4-bit Fibonacci LFSR. It supports any width, a tap mask, and Fibonacci or Galois form. It adds step-enable, seed load, all-zero lockup detection with optional auto-recovery, and an on-line period counter. It serves as the team's pseudo-random and test-pattern source; a single instance drives one sequence.

## Interface
- WIDTH, 8: register width in bits, ≥ 2.
- TAPS, 8'hB8: WIDTH-bit tap mask; bit i set means state[i] participates in feedback.
- GALOIS, 0: 0 selects Fibonacci form, 1 selects Galois form.
- RESET_SEED, 1: WIDTH-bit nonzero state loaded on reset and on auto-recovery.
- AUTO_RECOVER, 1: 1 means a step while locked up loads RESET_SEED.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- seed  in  WIDTH  value captured on load.
- load  in  1  load seed this cycle.
- en  in  1  advance one step this cycle.
- state  out  WIDTH  current register contents.
- out_bit  out  1  serial output; always equals state[0].
- lockup  out  1  high while state == 0.
- period  out  WIDTH  last measured period, in steps.
- period_valid  out  1  one-cycle pulse when period updates.

## Operation
- Reset values:
  - state = RESET_SEED; ref_seed = RESET_SEED.
  - step_cnt = 0; period = 0; period_valid = 0.
  - lockup = 0.
- Priority per cycle: rst, then load, then en, otherwise hold.
- Load:
  - state = seed; ref_seed = seed; step_cnt = 0; period_valid = 0.
  - Loading zero is legal; lockup rises next cycle.
- Fibonacci step: fb = XOR-reduce(state & TAPS); next = {fb, state[WIDTH-1:1]}.
- Galois step: next = {1'b0, state[WIDTH-1:1]} XOR ({WIDTH{state[0]}} & TAPS).
- Lockup (state == 0):
  - With AUTO_RECOVER=1, en loads RESET_SEED and sets ref_seed = RESET_SEED, step_cnt = 0. No period pulse.
  - With AUTO_RECOVER=0, the state holds at 0 (the natural step result).
- Period measurement:
  - Each non-recovery step increments step_cnt.
  - When next == ref_seed: period = step_cnt + 1, period_valid = 1 on the following cycle, step_cnt = 0.
  - step_cnt saturates at all-ones. No pulse is issued while saturated until the next load or recovery.
- All arithmetic is unsigned, WIDTH bits. The maximal period 2^WIDTH − 1 fits.

## Timing
- All outputs are registered. A load or step on edge N is visible on state, out_bit and lockup after edge N.
- period and period_valid update on the same edge as the state that equals ref_seed. The pulse lasts exactly one cycle.
- load with en in the same cycle: load wins and no step occurs.
- Reset mid-sequence: the next cycle shows reset values; period history is lost.
- en held low: state, step_cnt and all flags hold; period_valid is 0.

## Structure
- Shared package lfsr_pkg holds:
  - the mode constants LFSR_FIB and LFSR_GALOIS;
  - a function lfsr_next(state, taps, galois) returning the next state, for reuse by the bench model.
- One natural sub-module, lfsr_period_mon: it owns ref_seed, step_cnt, period and period_valid, and is fed by step, load and next.

## Test plan
- WIDTH=4, TAPS=4'b0011, GALOIS=0, load 4'b1000, en held → state sequence 1000, 0100, 0010, 1001, 1100, 0110, 1011, 0101, 1010, 1101, 1110, 1111, 0111, 0011, 0001, 1000. period = 15 with a one-cycle period_valid on the return to 1000.
- WIDTH=4, TAPS=4'b1100, GALOIS=1, load 4'b0001 → sequence 0001, 1100, 0110, 0011, 1101, 1010, 0101, 1110, 0111, 1111, 1011, 1001, 1000, 0100, 0010, 0001. period = 15.
- Load 0, then en → lockup = 1. With AUTO_RECOVER=1, the next step yields RESET_SEED and clears lockup; with AUTO_RECOVER=0, state stays 0.
- load and en asserted together with seed 4'b0101 → state = 0101, no step, step_cnt = 0.
- Assert rst at step 7 of a sequence → next cycle state = RESET_SEED, period = 0, period_valid = 0.
- Toggle en randomly → the sequence matches lfsr_next applied only on en cycles, and period still equals 15.
